pb_debouncer: RTL and testbench

- Upstream conditioning stage for push-button inputs on the lab boards.
- Synchronises a raw, bouncing button signal and filters it with a stability counter.
- Emits a clean level, plus single-cycle press/release pulses.
- press_pulse drives the enable input of the downstream counter directly: one count per physical press.

---
 rtl/pb_debouncer_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pb_debouncer.sv | 149 ++++++++++++++
 tb/tb_pb_debouncer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pb_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer and its synchroniser.
// No logic lives here; every design file imports this package.
`timescale 1ns/1ps
package pb_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } pb_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; 2-cycle latency, no flow control.
// Reusable for any slow switch input that crosses into the clk domain.
`timescale 1ns/1ps
module sync_2ff
    import pb_debouncer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pb_debouncer.sv
// Push-button conditioner: sync, stability filter, clean level plus press/release pulses.
// Latency DEBOUNCE_CYCLES+2 edges from first sample to output; no backpressure.
// Optional auto-repeat on held button: define PB_DEBOUNCER_REPEAT_EN.
`timescale 1ns/1ps
module pb_debouncer
    import pb_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
)(
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("pb_debouncer: DEBOUNCE_CYCLES must be >= 2, HOLD/REPEAT_CYCLES >= 1");
    end

    logic             w_btn_sync;
    logic             w_cnt_done;
    logic             w_repeat_fire;
    pb_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (w_btn_sync)
    );

    assign w_cnt_done = (r_cnt == CNT_LAST);

`ifdef PB_DEBOUNCER_REPEAT_EN
    localparam int                HOLD_W      = $clog2(HOLD_CYCLES + REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_WRAP   = HOLD_W'(HOLD_CYCLES + REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    logic [HOLD_W-1:0] r_hold;

    // r_hold counts edges since the initial press pulse; it parks at HOLD_CYCLES after each repeat.
    assign w_repeat_fire = (r_state == PRESSED) && w_btn_sync &&
                           ((r_hold == HOLD_FIRST) || (r_hold == HOLD_WRAP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else begin
            case (r_state)
                PRESSED: begin
                    if (w_btn_sync) begin
                        if (r_hold == HOLD_WRAP) begin
                            r_hold <= HOLD_RELOAD;
                        end else begin
                            r_hold <= r_hold + HOLD_ONE;
                        end
                    end
                end
                RELEASE_WAIT: r_hold <= r_hold;
                default:      r_hold <= '0;
            endcase
        end
    end
`else
    assign w_repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_btn_pressed   <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_btn_pressed <= 1'b0;
                    r_cnt         <= '0;
                    if (w_btn_sync) begin
                        r_state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state       <= PRESSED;
                        r_cnt         <= '0;
                        r_btn_pressed <= 1'b1;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    r_btn_pressed <= 1'b1;
                    r_cnt         <= '0;
                    if (!w_btn_sync) begin
                        r_state <= RELEASE_WAIT;
                    end else if (w_repeat_fire) begin
                        r_press_pulse <= 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to 1 returns to PRESSED silently: the press was already reported.
                    if (w_btn_sync) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state         <= IDLE;
                        r_cnt           <= '0;
                        r_btn_pressed   <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_cnt         <= '0;
                    r_btn_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign btn_pressed   = r_btn_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

endmodule

// File: tb/tb_pb_debouncer.sv
// Directed bench for pb_debouncer with DEBOUNCE=8, HOLD=20, REPEAT=5.
`timescale 1ns/1ps
module tb_pb_debouncer;
    import pb_debouncer_pkg::*;

    logic clk;
    logic reset;
    logic btn_in;
    logic btn_pressed;
    logic press_pulse;
    logic release_pulse;

    int tests_run;
    int tests_failed;
    int n_press;
    int n_rel;
    int n_low;
    int n_both;

    pb_debouncer #(
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_pressed   (btn_pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_press = 0;
        n_rel   = 0;
        n_low   = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_press += int'(press_pulse);
            n_rel   += int'(release_pulse);
            if (!btn_pressed) n_low++;
            if (press_pulse && release_pulse) n_both++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rep40;
        tests_run    = 0;
        tests_failed = 0;
        n_both       = 0;
        clr();
`ifdef PB_DEBOUNCER_REPEAT_EN
        exp_rep40 = 3;
`else
        exp_rep40 = 0;
`endif

        // Reset held with button pressed: everything stays quiet.
        reset  = 1'b1;
        btn_in = 1'b1;
        step(3);
        check("rst_pressed", btn_pressed, 0);
        check("rst_press_pulse", press_pulse, 0);
        check("rst_release_pulse", release_pulse, 0);
        check("rst_state", dut.r_state, IDLE);
        reset = 1'b0;
        clr();
        step(10);
        check("rst_latency_low", btn_pressed, 0);
        step(1);
        check("rst_latency_high", btn_pressed, 1);
        check("rst_latency_pulse", press_pulse, 1);
        step(1);
        check("rst_pulse_one_cycle", press_pulse, 0);
        check("rst_single_press", n_press, 1);

        btn_in = 1'b0;
        clr();
        step(10);
        check("rel1_still_pressed", btn_pressed, 1);
        step(1);
        check("rel1_pressed_low", btn_pressed, 0);
        check("rel1_release_pulse", release_pulse, 1);
        step(1);
        check("rel1_release_one_cycle", release_pulse, 0);
        check("rel1_no_press", n_press, 0);
        step(5);

        // Clean press held, then clean release.
        btn_in = 1'b1;
        clr();
        step(10);
        check("clean_pre_accept", btn_pressed, 0);
        step(1);
        check("clean_accept_level", btn_pressed, 1);
        check("clean_accept_pulse", press_pulse, 1);
        clr();
        step(30);
        check("clean_hold_pulses", n_press, exp_rep40);
        check("clean_hold_level", n_low, 0);
        btn_in = 1'b0;
        clr();
        step(10);
        check("clean_rel_wait_no_pulse", n_rel + n_press, 0);
        step(1);
        check("clean_rel_level", btn_pressed, 0);
        check("clean_rel_pulse", release_pulse, 1);
        step(5);

        // Glitch shorter than the debounce window is ignored.
        clr();
        btn_in = 1'b1;
        step(7);
        btn_in = 1'b0;
        step(12);
        check("glitch_no_pulse", n_press, 0);
        check("glitch_level_low", n_low, 19);

        // Bouncing press, then settled high.
        clr();
        btn_in = 1'b1; step(3);
        btn_in = 1'b0; step(3);
        btn_in = 1'b1; step(3);
        btn_in = 1'b0; step(3);
        btn_in = 1'b1;
        step(10);
        check("bounce_no_pulse", n_press, 0);
        check("bounce_pre_accept", btn_pressed, 0);
        step(1);
        check("bounce_accept_level", btn_pressed, 1);
        check("bounce_accept_pulse", press_pulse, 1);

        // Release bounce: short low dip must not release.
        clr();
        btn_in = 1'b0; step(4);
        btn_in = 1'b1; step(15);
        check("relbounce_level", n_low, 0);
        check("relbounce_no_release", n_rel, 0);
        check("relbounce_no_press", n_press, 0);
        btn_in = 1'b0;
        clr();
        step(10);
        step(1);
        check("relbounce_final_release", release_pulse, 1);
        check("relbounce_final_one", n_rel, 1);
        check("relbounce_final_no_press", n_press, 0);
        step(5);

`ifdef PB_DEBOUNCER_REPEAT_EN
        // Auto-repeat while held: pulses at +20, then every 5.
        btn_in = 1'b1;
        step(10);
        step(1);
        check("rep_accept_pulse", press_pulse, 1);
        clr();
        step(19);
        check("rep_before_first", n_press, 0);
        step(1);
        check("rep_first_pulse", press_pulse, 1);
        step(30);
        check("rep_total_repeats", n_press, 7);
        btn_in = 1'b0;
        clr();
        step(10);
        check("rep_rel_no_press", n_press, 0);
        step(1);
        check("rep_rel_pulse", release_pulse, 1);
        step(5);
`endif

        // Async reset right after acceptance clears outputs without an edge.
        btn_in = 1'b1;
        step(11);
        check("arst_pre_pulse", press_pulse, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_pulse_cleared", press_pulse, 0);
        check("arst_level_cleared", btn_pressed, 0);
        #1 reset = 1'b0;
        step(10);
        check("arst_relatency_low", btn_pressed, 0);
        step(1);
        check("arst_relatency_high", btn_pressed, 1);
        btn_in = 1'b0;
        step(15);

        // Async reset mid PRESS_WAIT with count at 5.
        btn_in = 1'b1;
        step(8);
        check("midwait_state", dut.r_state, PRESS_WAIT);
        check("midwait_count", dut.r_cnt, 5);
        #2 reset = 1'b1;
        #1;
        check("midwait_arst_state", dut.r_state, IDLE);
        check("midwait_arst_level", btn_pressed, 0);
        #1 reset = 1'b0;
        clr();
        step(10);
        check("midwait_full_interval", n_press, 0);
        step(1);
        check("midwait_accept_level", btn_pressed, 1);
        check("midwait_accept_pulse", press_pulse, 1);
        btn_in = 1'b0;
        step(15);

        check("pulses_exclusive", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
